// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper: FSM states, winner codes,
// seven-segment glyphs and the BCD score arithmetic.
package score_keeper_pkg;

    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned AN_W     = 4;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_BOTH = 2'b11;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // BCD +1 with ones-to-tens carry, saturating at 99.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
        if (s == 8'h99) begin
            return 8'h99;
        end
        if (s[3:0] == 4'd9) begin
            return {s[7:4] + 4'd1, 4'd0};
        end
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // Score after this cycle's events; a clear beats a simultaneous hit.
    function automatic logic [SCORE_W-1:0] next_score(input logic [SCORE_W-1:0] s,
                                                      input logic              inc,
                                                      input logic              clr);
        if (clr) begin
            return '0;
        end
        if (inc) begin
            return bcd_inc(s);
        end
        return s;
    endfunction

endpackage

// File: rtl/score_keeper_bcd_to_7seg.sv
// BCD nibble to active-low seven-segment glyph; non-decimal codes blank.
module bcd_to_7seg
    import score_keeper_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_i,
    output logic [SEG_W-1:0]    seg_c_o
);

    // Glyph lookup.
    always_comb begin
        seg_c_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_c_o = SEG_0;
            4'd1:    seg_c_o = SEG_1;
            4'd2:    seg_c_o = SEG_2;
            4'd3:    seg_c_o = SEG_3;
            4'd4:    seg_c_o = SEG_4;
            4'd5:    seg_c_o = SEG_5;
            4'd6:    seg_c_o = SEG_6;
            4'd7:    seg_c_o = SEG_7;
            4'd8:    seg_c_o = SEG_8;
            4'd9:    seg_c_o = SEG_9;
            default: seg_c_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// Two-player rally score keeper: edge-detected hit/miss events drive BCD
// scores through an IDLE/PLAY/OVER match FSM, shown on a 4-digit
// time-multiplexed seven-segment display.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter logic [7:0]  WIN_SCORE   = 8'h15,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit1,
    input  logic               hit2,
    input  logic               point_reset1,
    input  logic               point_reset2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [AN_W-1:0]    an,
    output logic [SEG_W-1:0]   seg
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic start_s1_q, start_s2_q, start_q;
    logic hit1_q, hit2_q, pr1_q, pr2_q;
    logic start_ev_c, hit1_ev_c, hit2_ev_c, pr1_ev_c, pr2_ev_c;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [1:0]         winner_q, winner_d;
    logic               game_over_q;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [AN_W-1:0]     an_q;
    logic [SEG_W-1:0]    seg_q;
    logic [NIBBLE_W-1:0] nibble_c;
    logic [SEG_W-1:0]    seg_c;
    logic                win1_c, win2_c;

    // Start synchronizer plus previous-level copies for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_q    <= 1'b0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            pr1_q      <= 1'b0;
            pr2_q      <= 1'b0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_q    <= start_s2_q;
            hit1_q     <= hit1;
            hit2_q     <= hit2;
            pr1_q      <= point_reset1;
            pr2_q      <= point_reset2;
        end
    end

    assign start_ev_c = start_s2_q & ~start_q;
    assign hit1_ev_c  = hit1 & ~hit1_q;
    assign hit2_ev_c  = hit2 & ~hit2_q;
    assign pr1_ev_c   = point_reset1 & ~pr1_q;
    assign pr2_ev_c   = point_reset2 & ~pr2_q;

    assign win1_c = (score1_q == WIN_SCORE);
    assign win2_c = (score2_q == WIN_SCORE);

    // Match FSM next-state and score/winner update.
    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ev_c) begin
                    state_d  = ST_PLAY;
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WINNER_NONE;
                end
            end
            ST_PLAY: begin
                // A score sitting at the target decides the match; no more scoring.
                if (win1_c || win2_c) begin
                    state_d = ST_OVER;
                    if (win1_c && win2_c) begin
                        winner_d = WINNER_BOTH;
                    end else if (win1_c) begin
                        winner_d = WINNER_P1;
                    end else begin
                        winner_d = WINNER_P2;
                    end
                end else begin
                    score1_d = next_score(score1_q, hit1_ev_c, pr1_ev_c);
                    score2_d = next_score(score2_q, hit2_ev_c, pr2_ev_c);
                end
            end
            ST_OVER: begin
                if (start_ev_c) begin
                    state_d  = ST_PLAY;
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WINNER_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Match state, scores and winner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            score1_q    <= '0;
            score2_q    <= '0;
            winner_q    <= WINNER_NONE;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            game_over_q <= (state_d == ST_OVER);
        end
    end

    // Refresh counter and digit index for the display multiplexer.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Nibble for the next digit slot, taken from next-cycle scores so seg lines up with an.
    always_comb begin
        nibble_c = score1_d[3:0];
        case (idx_d)
            2'd0:    nibble_c = score1_d[3:0];
            2'd1:    nibble_c = score1_d[7:4];
            2'd2:    nibble_c = score2_d[3:0];
            default: nibble_c = score2_d[7:4];
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .digit_i (nibble_c),
        .seg_c_o (seg_c)
    );

    // Display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1110;
            seg_q <= SEG_0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= ~(AN_W'(1) << idx_d);
            seg_q <= seg_c;
        end
    end

    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal-score reference model pushes the
// expected post-edge outputs per cycle; a monitor pops and compares them.
module tb_score_keeper;

    localparam int unsigned DIV = 4;
    localparam int          WIN = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hit1 = 1'b0, hit2 = 1'b0, pr1 = 1'b0, pr2 = 1'b0;
    logic [7:0] score1, score2;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(8'h15), .REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hit1         (hit1),
        .hit2         (hit2),
        .point_reset1 (pr1),
        .point_reset2 (pr2),
        .score1       (score1),
        .score2       (score2),
        .game_over    (game_over),
        .winner       (winner),
        .an           (an),
        .seg          (seg)
    );

    typedef struct packed {
        logic [7:0] s1;
        logic [7:0] s2;
        logic       go;
        logic [1:0] win;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: scores as plain decimal integers, mode 0 idle, 1 play, 2 over.
    int   m_mode = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_n = 0;
    bit   ph1 = 0, ph2 = 0, pp1 = 0, pp2 = 0;
    bit   sh0 = 0, sh1 = 0, sh2 = 0;
    logic [6:0] glyph [0:15];

    initial begin
        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
        glyph[8] = 7'h00; glyph[9] = 7'h10;
        for (int i = 10; i < 16; i++) glyph[i] = 7'h7F;
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected outputs.
    task automatic step(input bit h1, input bit h2, input bit p1, input bit p2,
                        input bit st, input bit r);
        exp_t       e;
        bit         sev, e1h, e2h, e1c, e2c;
        int         idx;
        logic [7:0] b1, b2;
        logic [3:0] nib;
        logic [3:0] one;
        @(negedge clk);
        rst = r; start = st; hit1 = h1; hit2 = h2; pr1 = p1; pr2 = p2;
        if (r) begin
            m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_n = 0;
            ph1 = 0; ph2 = 0; pp1 = 0; pp2 = 0;
            sh0 = 0; sh1 = 0; sh2 = 0;
        end else begin
            sev = sh1 && !sh2;
            sh2 = sh1; sh1 = sh0; sh0 = st;
            e1h = h1 && !ph1; ph1 = h1;
            e2h = h2 && !ph2; ph2 = h2;
            e1c = p1 && !pp1; pp1 = p1;
            e2c = p2 && !pp2; pp2 = p2;
            if (m_mode == 1) begin
                if (m_s1 == WIN || m_s2 == WIN) begin
                    m_mode = 2;
                    m_win  = ((m_s1 == WIN) ? 1 : 0) + ((m_s2 == WIN) ? 2 : 0);
                end else begin
                    if (e1c)      m_s1 = 0;
                    else if (e1h) m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
                    if (e2c)      m_s2 = 0;
                    else if (e2h) m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
                end
            end else if (sev) begin
                m_mode = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
            m_n++;
        end
        b1  = to_bcd(m_s1);
        b2  = to_bcd(m_s2);
        idx = (m_n / DIV) % 4;
        one = 4'b0001;
        case (idx)
            0:       nib = b1[3:0];
            1:       nib = b1[7:4];
            2:       nib = b2[3:0];
            default: nib = b2[7:4];
        endcase
        e.s1  = b1;
        e.s2  = b2;
        e.go  = (m_mode == 2);
        e.win = 2'(m_win);
        e.an  = ~(one << idx);
        e.seg = glyph[nib];
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // who: 1 hit1, 2 hit2, 3 point_reset1, 4 point_reset2.
    task automatic pulse(input int who, input int hi, input int lo);
        for (int i = 0; i < hi; i++)
            step(who == 1, who == 2, who == 3, who == 4, 0, 0);
        idle(lo);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every sampled output set against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("score1",    32'(score1),    32'(e.s1));
                chk("score2",    32'(score2),    32'(e.s2));
                chk("game_over", 32'(game_over), 32'(e.go));
                chk("winner",    32'(winner),    32'(e.win));
                chk("an",        32'(an),        32'(e.an));
                chk("seg",       32'(seg),       32'(e.seg));
            end
        end
    end

    // Directed scenarios followed by randomized play.
    initial begin
        bit rh1, rh2, rp1, rp2, rst_l;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        idle(4);

        for (int i = 0; i < 12; i++) pulse(1, 3, 2);
        after_edge();
        chk("twelve_hits_s1", 32'(score1), 32'h12);
        chk("twelve_hits_s2", 32'(score2), 32'h00);
        chk("twelve_hits_go", 32'(game_over), 32'h0);
        idle(20);

        pulse(3, 1, 2);
        for (int i = 0; i < 9; i++) pulse(1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        after_edge();
        chk("carry_09_to_10", 32'(score1), 32'h10);
        idle(2);

        for (int i = 0; i < 7; i++) pulse(2, 1, 1);
        step(0, 1, 0, 1, 0, 0);
        after_edge();
        chk("clear_beats_hit", 32'(score2), 32'h00);
        idle(2);

        pulse(3, 1, 1);
        for (int i = 0; i < 15; i++) pulse(1, 1, 1);
        idle(1);
        after_edge();
        chk("win_game_over", 32'(game_over), 32'h1);
        chk("win_winner",    32'(winner),    32'h1);
        for (int i = 0; i < 3; i++) pulse(2, 1, 1);
        after_edge();
        chk("over_s2_frozen", 32'(score2), 32'h00);
        chk("over_s1_frozen", 32'(score1), 32'h15);
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        after_edge();
        chk("restart_s1",  32'(score1),    32'h00);
        chk("restart_s2",  32'(score2),    32'h00);
        chk("restart_win", 32'(winner),    32'h0);
        chk("restart_go",  32'(game_over), 32'h0);

        for (int i = 0; i < 4; i++) pulse(1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        after_edge();
        chk("reset_mid_s1", 32'(score1),    32'h00);
        chk("reset_mid_go", 32'(game_over), 32'h0);
        pulse(1, 1, 1);
        pulse(1, 1, 1);

        rh1 = 0; rh2 = 0; rp1 = 0; rp2 = 0; rst_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 0)  rh1 = !rh1;
            if ($urandom_range(0, 1) == 0)  rh2 = !rh2;
            if ($urandom_range(0, 59) == 0) rp1 = !rp1;
            if ($urandom_range(0, 59) == 0) rp2 = !rp2;
            if ($urandom_range(0, 29) == 0) rst_l = !rst_l;
            step(rh1, rh2, rp1, rp2, rst_l, $urandom_range(0, 999) == 0);
        end
        idle(3);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
